// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: byte write, or random read with repeated START, to a 7-bit device.
// Optional NACK detection/abort is enabled by defining I2C_MASTER_ACKCHK_EN.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_id,
  input  logic [7:0] word_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL,
  inout  wire        SDA
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RESTART,
    S_RX_BYTE, S_TX_NACK, S_STOP, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic [1:0]       qtr, last_q, byte_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh, rx_sh, cmd_wa, cmd_wd;
  logic [6:0]       cmd_dev;
  logic             cmd_rw, q_tick, cell_end, sample, nack_abort, sda_low, sda_in;

  // Open-drain: only ever pull low, otherwise float and let the pull-up win.
  assign SDA    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  // START lasts 2Q, STOP 3Q, every other phase is a 4Q bit cell.
  always_comb begin
    case (state)
      S_START: last_q = 2'd1;
      S_STOP:  last_q = 2'd2;
      default: last_q = 2'd3;
    endcase
  end

  assign q_tick   = (div == DIV_LAST);
  assign cell_end = q_tick && (qtr == last_q);
  assign sample   = q_tick && (qtr == 2'd2);

  // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_START;
      S_START:   if (cell_end) state_nxt = S_TX_BYTE;
      S_TX_BYTE: if (cell_end && bit_cnt == 3'd0) state_nxt = S_RX_ACK;
      S_RX_ACK: begin
        if (cell_end) begin
          if (nack_abort)             state_nxt = S_STOP;
          else if (byte_cnt == 2'd0)  state_nxt = S_TX_BYTE;
          else if (byte_cnt == 2'd1)  state_nxt = cmd_rw ? S_RESTART : S_TX_BYTE;
          else                        state_nxt = cmd_rw ? S_RX_BYTE : S_STOP;
        end
      end
      S_RESTART: if (cell_end) state_nxt = S_TX_BYTE;
      S_RX_BYTE: if (cell_end && bit_cnt == 3'd0) state_nxt = S_TX_NACK;
      S_TX_NACK: if (cell_end) state_nxt = S_STOP;
      S_STOP:    if (cell_end) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    SCL     = 1'b1;
    sda_low = 1'b0;
    busy    = (state != S_IDLE) && (state != S_DONE);
    done    = (state == S_DONE);
    case (state)
      S_START:   sda_low = (qtr == 2'd1);
      S_TX_BYTE: begin
        SCL     = qtr[1];
        sda_low = ~tx_sh[7];
      end
      S_RX_ACK, S_RX_BYTE, S_TX_NACK: SCL = qtr[1];
      S_RESTART: begin
        SCL     = qtr[1];
        sda_low = (qtr == 2'd3);
      end
      S_STOP: begin
        SCL     = (qtr != 2'd0);
        sda_low = (qtr != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rd_data  <= '0;
      cmd_rw   <= 1'b0;
      cmd_dev  <= '0;
      cmd_wa   <= '0;
      cmd_wd   <= '0;
    end else begin
      // Timing restarts at Q0 on every phase change; inside a phase the quarter simply wraps.
      if (state_nxt != state || state == S_IDLE || state == S_DONE) begin
        div <= '0;
        qtr <= '0;
      end else begin
        div <= q_tick ? '0 : div + 1'b1;
        if (q_tick) qtr <= qtr + 2'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_rw  <= rw;
            cmd_dev <= dev_id;
            cmd_wa  <= word_addr;
            cmd_wd  <= wr_data;
          end
        end
        S_START: begin
          if (cell_end) begin
            tx_sh    <= {cmd_dev, 1'b0};
            bit_cnt  <= 3'd7;
            byte_cnt <= 2'd0;
          end
        end
        S_TX_BYTE: begin
          if (cell_end) begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        S_RX_ACK: begin
          if (cell_end) begin
            byte_cnt <= byte_cnt + 2'd1;
            bit_cnt  <= 3'd7;
            tx_sh    <= (byte_cnt == 2'd0) ? cmd_wa : cmd_wd;
          end
        end
        S_RESTART: begin
          if (cell_end) begin
            tx_sh   <= {cmd_dev, 1'b1};
            bit_cnt <= 3'd7;
          end
        end
        S_RX_BYTE: begin
          if (sample) rx_sh <= {rx_sh[6:0], sda_in};
          if (cell_end) begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) rd_data <= rx_sh;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_MASTER_ACKCHK_EN
  always_ff @(posedge clk) begin
    if (rst)                                    ack_err <= 1'b0;
    else if (state == S_IDLE && start)          ack_err <= 1'b0;
    else if (state == S_RX_ACK && sample && sda_in) ack_err <= 1'b1;
  end
  // ack_err can only be set in the current ACK slot, since an earlier NACK already aborted.
  assign nack_abort = ack_err;
`else
  assign ack_err    = 1'b0;
  assign nack_abort = 1'b0;
`endif

endmodule
